// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 16:1 mux: steps the select through every input, waits a
// settle interval after each change, samples the mux output and publishes the
// reassembled word once a full sweep has been captured.
module mux_scan_sequencer #(
    parameter int unsigned N_INPUTS = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic                abort,
    input  logic                mux_in,
    output logic [SEL_W-1:0]    sel_out,
    output logic                busy,
    output logic [N_INPUTS-1:0] word_out,
    output logic                word_valid
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSample} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_INPUTS-1:0] shadow_q, shadow_d;
    logic [N_INPUTS-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                cont_q, cont_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cont_q   <= cont_d;
        end
    end

    // Next-state logic; abort outranks completion of the current bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWait;
            end
            StWait: begin
                if (abort)                 state_d = StIdle;
                else if (cnt_q == CNT_LAST) state_d = StSample;
            end
            StSample: begin
                if (abort)                               state_d = StIdle;
                else if ((sel_q == SEL_LAST) && !cont_q) state_d = StIdle;
                else                                     state_d = StWait;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values for select, settle counter, shadow word and published word.
    always_comb begin
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        cont_d   = cont_q;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                cnt_d = '0;
                if (start) cont_d = cont;
            end
            StWait: begin
                if (abort) begin
                    sel_d    = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            StSample: begin
                cnt_d = '0;
                if (abort) begin
                    sel_d    = '0;
                    shadow_d = '0;
                end else begin
                    shadow_d[sel_q] = mux_in;
                    if (sel_q == SEL_LAST) begin
                        // Publish straight from the updated shadow so the last bit
                        // lands in the same word without an extra cycle.
                        word_d  = shadow_d;
                        valid_d = 1'b1;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: begin
                sel_d = '0;
                cnt_d = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // Outputs come straight from registers so the mux select never glitches.
    always_comb begin
        sel_out    = sel_q;
        busy       = busy_q;
        word_out   = word_q;
        word_valid = valid_q;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 16:1 mux closes the loop and
// each scenario compares outputs against hand-computed values.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] vec = 16'h0000, vec2 = 16'h0000;
    logic        b0 = 1'b0;
    logic        mux_in, mux_in2;
    logic [3:0]  sel_out, sel_out2;
    logic        busy, busy2, word_valid, word_valid2;
    logic [15:0] word_out, word_out2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    always #5 clk = ~clk;

    assign mux_in  = vec[sel_out];
    assign mux_in2 = (sel_out2 == 4'd0) ? b0 : vec2[sel_out2];

    mux_scan_sequencer #(.N_INPUTS(16), .SEL_W(4), .SETTLE(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .mux_in     (mux_in),
        .sel_out    (sel_out),
        .busy       (busy),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    mux_scan_sequencer #(.N_INPUTS(16), .SEL_W(4), .SETTLE(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .cont       (1'b0),
        .abort      (1'b0),
        .mux_in     (mux_in2),
        .sel_out    (sel_out2),
        .busy       (busy2),
        .word_out   (word_out2),
        .word_valid (word_valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_scan(input logic c);
        start = 1'b1;
        cont  = c;
        t0    = cyc;
        tick();
        start = 1'b0;
        cont  = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] s);
        int n = 0;
        while (sel_out != s && n < 100) begin
            tick();
            n++;
        end
        check("reach_sel", 32'(sel_out), 32'(s));
    endtask

    task automatic wait_valid(input bit second);
        int n = 0;
        while (((second ? word_valid2 : word_valid) == 1'b0) && n < 200) begin
            tick();
            n++;
        end
    endtask

    // SETTLE=3 run: bit 0 toggles through the WAIT cycles, final value on SAMPLE.
    task automatic run_settle3(input logic final_v, input logic [15:0] exp_word);
        b0     = ~final_v;
        start2 = 1'b1;
        t0     = cyc;
        tick();
        start2 = 1'b0;
        b0 = ~final_v;
        tick();
        b0 = final_v;
        tick();
        b0 = ~final_v;
        tick();
        b0 = final_v;
        check("s3_sel_at_sample", 32'(sel_out2), 32'd0);
        wait_valid(1'b1);
        check("s3_latency", 32'(cyc - t0), 32'd65);
        check("s3_word", 32'(word_out2), 32'(exp_word));
        tick();
    endtask

    initial begin
        int pulses;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);

        // Single scan of 16'hA5C3
        vec = 16'hA5C3;
        start_scan(1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_low_in_scan", 32'(word_valid), 32'd0);
        wait_valid(1'b0);
        check("single_latency", 32'(cyc - t0), 32'd33);
        check("single_word", 32'(word_out), 32'h0000A5C3);
        tick();
        check("single_pulse_once", 32'(word_valid), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_sel", 32'(sel_out), 32'd0);

        // Reset mid-scan at bit 7
        vec = 16'hFFFF;
        start_scan(1'b0);
        wait_sel(4'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sel", 32'(sel_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_word", 32'(word_out), 32'd0);
        check("midrst_valid", 32'(word_valid), 32'd0);

        // Continuous mode, input changes between scans
        vec = 16'h00FF;
        start_scan(1'b1);
        wait_valid(1'b0);
        check("cont_first_latency", 32'(cyc - t0), 32'd33);
        check("cont_first_word", 32'(word_out), 32'h000000FF);
        vec = 16'hFF00;
        t0  = cyc;
        tick();
        check("cont_pulse_width", 32'(word_valid), 32'd0);
        check("cont_still_busy", 32'(busy), 32'd1);
        wait_valid(1'b0);
        check("cont_period", 32'(cyc - t0), 32'd32);
        check("cont_second_word", 32'(word_out), 32'h0000FF00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("cont_abort_busy", 32'(busy), 32'd0);
        check("cont_abort_sel", 32'(sel_out), 32'd0);

        // start re-pulsed (with cont=1) at bit 5 is ignored
        vec = 16'h3C69;
        start_scan(1'b0);
        wait_sel(4'd5);
        start = 1'b1;
        cont  = 1'b1;
        tick();
        start = 1'b0;
        cont  = 1'b0;
        wait_valid(1'b0);
        check("restart_latency", 32'(cyc - t0), 32'd33);
        check("restart_word", 32'(word_out), 32'h00003C69);
        tick();
        check("restart_single_mode", 32'(busy), 32'd0);

        // Abort at bit 10 keeps the prior word
        vec = 16'h1234;
        start_scan(1'b0);
        wait_valid(1'b0);
        check("prior_word", 32'(word_out), 32'h00001234);
        tick();
        vec = 16'hFFFF;
        start_scan(1'b0);
        wait_sel(4'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(sel_out), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (word_valid) pulses++;
            tick();
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        check("abort_word_kept", 32'(word_out), 32'h00001234);

        // SETTLE=3: only the SAMPLE-cycle value of bit 0 is captured
        vec2 = 16'h5A5A;
        run_settle3(1'b0, 16'h5A5A);
        run_settle3(1'b1, 16'h5A5B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
